serial_comp_ctrl: RTL
=====================

Name: serial_comp_ctrl

Overview:
- Sequencing controller that compares two WIDTH-bit unsigned operands by stepping a single 2-bit comparator slice (comp_2) across them, MSB slice first.
- Stops early at the first unequal slice.
- Accepts operands through a valid/ready input handshake and returns a one-hot L/E/G result through a valid/ready output handshake.
- Serves as the area-cheap wide comparator in the arithmetic IP set; one comp_2 is reused for any operand width.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2.
- NSLICE, WIDTH/2, number of 2-bit slices; derived, not overridden.
- CW, $clog2(NSLICE)+1, width of the slice-count output.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands A/B are valid.
- in_ready  output  1  controller can accept operands.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- L  output  1  A < B.
- E  output  1  A == B.
- G  output  1  A > B.
- nslices  output  CW  number of slices examined for the current result, 1..NSLICE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - out_valid=0, L=E=G=0, nslices=0, in_ready=1.
  - Operand registers and the slice index are cleared.
- States: IDLE, SCAN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - Accept when in_valid and in_ready are both high at a clock edge (cycle c0).
  - Register A and B, set idx=NSLICE-1, set nslices=0, go to SCAN.
  - With in_valid low, stay in IDLE.
- SCAN, one slice per cycle:
  - comp_2 sees A_r[2*idx+1:2*idx] and B_r[2*idx+1:2*idx]; nslices increments by 1 each SCAN cycle.
  - If the slice reports L or G: latch that flag, go to DONE.
  - Else if idx==0: latch E, go to DONE.
  - Else: decrement idx, stay in SCAN.
- Latency:
  - Slice NSLICE-1 is evaluated in cycle c0+1.
  - The deciding slice k (k = slices examined) is evaluated in cycle c0+k.
  - out_valid is high from cycle c0+k+1.
  - Best case is 2 cycles from accept to out_valid; worst case is NSLICE+1.
- DONE:
  - L/E/G are exactly one-hot and held stable with nslices while out_ready is low.
  - On out_valid & out_ready, go to IDLE; out_valid, L, E and G return to 0 in the next cycle.
  - nslices holds its last value until the next accept.
- Outside DONE, L=E=G=0.
- No bypass: in_ready is 0 during the DONE-release cycle. The earliest next accept is the cycle after release, so back-to-back throughput is one result per k+2 cycles.
- in_valid and operand changes while not in IDLE are ignored; the registered operands alone drive the comparison.
- Reset during SCAN or DONE aborts the operation immediately. out_valid drops asynchronously, no result is produced, and the operands are discarded.
- WIDTH=2 degenerates to one SCAN cycle; the result must equal comp_2 for all inputs.
- An odd WIDTH or WIDTH < 2 is an elaboration-time error via a generate-time check.

Decomposition:
- Shared package (arith_pkg):
  - State encoding constants IDLE/SCAN/DONE (2-bit).
  - SLICE_W=2 constant.
  - Result-encoding constants for L/E/G.
- One sub-module instance: comp_2, the existing combinational 2-bit comparator with ports A[1:0], B[1:0], L, E, G. It is instantiated once as the slice datapath.
- FSM, index counter and result registers live in serial_comp_ctrl.

Test Plan:
1. WIDTH=8, A=8'hA5, B=8'hA5, out_ready=1 -> E=1, L=G=0, nslices=4, out_valid first high 5 cycles after the accept edge.
2. WIDTH=8, A=8'hC0, B=8'h80 -> G=1, nslices=1, out_valid 2 cycles after accept; A=8'h34, B=8'h3C -> L=1, nslices=3, out_valid 4 cycles after accept.
3. Back-pressure: A=8'h01, B=8'h02 with out_ready low for 5 cycles -> out_valid and L=1 held stable, in_ready=0 throughout; out_ready high for 1 cycle -> out_valid=0 and in_ready=1 the next cycle.
4. Operand change mid-SCAN: accept A=8'hFF, B=8'h00, then drive A=8'h00 and keep in_valid high -> result still G=1, nslices=1; the second transaction is not accepted until in_ready=1.
5. Reset mid-operation: accept A=8'h55, B=8'h55, assert rst_n low in the 2nd SCAN cycle -> out_valid, L, E, G and nslices are 0 immediately and in_ready=1; after release, a new compare of 8'h10 vs 8'h20 gives L=1.
6. WIDTH=2 exhaustive: all 16 A/B pairs -> L/E/G match the comp_2 truth table, nslices=1, out_valid 2 cycles after each accept.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic IP set: controller state encoding,
// comparator slice width and the one-hot {L,E,G} result codes.
package arith_pkg;

    // Every wide comparison is built from 2-bit comparator slices.
    localparam int SLICE_W = 2;

    // Sequencing controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    // Result vector is packed as {L, E, G}.
    typedef logic [2:0] res_t;

    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_L    = 3'b100;
    localparam res_t RES_E    = 3'b010;
    localparam res_t RES_G    = 3'b001;

endpackage

// File: rtl/comp_2.sv
// Combinational 2-bit unsigned comparator slice; exactly one of L/E/G is high.
module comp_2 (
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic       L,
    output logic       E,
    output logic       G
);

    assign L = (A < B);
    assign E = (A == B);
    assign G = (A > B);

endmodule

// File: rtl/serial_comp_ctrl.sv
// Wide unsigned comparator that reuses a single comp_2 slice, scanning the
// registered operands MSB slice first and stopping at the first unequal slice.
module serial_comp_ctrl
    import arith_pkg::*;
#(
    parameter  int WIDTH  = 8,
    localparam int NSLICE = WIDTH / SLICE_W,
    localparam int CW     = $clog2(NSLICE) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             L,
    output logic             E,
    output logic             G,
    output logic [CW-1:0]    nslices
);

    // Slice index needs at least one bit even when there is a single slice.
    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // Reject operand widths that cannot be split into whole 2-bit slices.
    if ((WIDTH < 2) || ((WIDTH % SLICE_W) != 0)) begin : g_width_check
        $error("serial_comp_ctrl: WIDTH must be even and >= 2");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    nslices_q, nslices_d;
    res_t             res_q, res_d;

    logic [1:0]       slice_a, slice_b;
    logic             slice_l, slice_e, slice_g;

    // Route the slice selected by idx_q from the registered operands to comp_2.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IW'(i)) begin
                slice_a = a_q[SLICE_W*i +: SLICE_W];
                slice_b = b_q[SLICE_W*i +: SLICE_W];
            end
        end
    end

    comp_2 u_comp_2 (
        .A (slice_a),
        .B (slice_b),
        .L (slice_l),
        .E (slice_e),
        .G (slice_g)
    );

    // Next-state, operand capture, slice stepping and result latching.
    // NOTE: every _d signal takes its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        nslices_d = nslices_q;
        res_d     = res_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d       = A;
                    b_d       = B;
                    idx_d     = IW'(NSLICE - 1);
                    nslices_d = '0;
                    state_d   = SCAN;
                end
            end

            SCAN: begin
                nslices_d = nslices_q + CW'(1);
                if (slice_l) begin
                    res_d   = RES_L;
                    state_d = DONE;
                end else if (slice_g) begin
                    res_d   = RES_G;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    // All slices equal down to the LSB slice.
                    res_d   = RES_E;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end

            DONE: begin
                // Result is held until the consumer takes it; nslices stays
                // visible until the next accept.
                if (out_ready) begin
                    res_d   = RES_NONE;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                res_d   = RES_NONE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    // NOTE: registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            nslices_q <= '0;
            res_q     <= RES_NONE;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            nslices_q <= nslices_d;
            res_q     <= res_d;
        end
    end

    // res_q is only non-zero in DONE, so L/E/G are zero in every other state.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign {L, E, G} = res_q;
    assign nslices   = nslices_q;

endmodule
